node_table_loader: RTL

NODE_TABLE_LOADER -- requirements
Module: node_table_loader

---
 rtl/node_table_loader.sv | 100 ++++++++++
 1 files changed

// File: rtl/node_table_loader.sv
// node_table_loader: byte-stream frame decoder that loads coefficient and child SRAMs for a node table
module node_table_loader #(
  parameter int ADDR_WIDTH  = 6,
  parameter int COEF_WIDTH  = 48,
  parameter int CHILD_WIDTH = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [ADDR_WIDTH-1:0]  coef_addr,
  output logic                   coef_write,
  output logic [COEF_WIDTH-1:0]  coef_data,
  output logic [ADDR_WIDTH-1:0]  child_addr,
  output logic                   child_write,
  output logic [CHILD_WIDTH-1:0] child_data,
  output logic                   tree_ready,
  output logic                   busy,
  output logic [6:0]             node_count,
  output logic [7:0]             err_count
);
  typedef enum logic [2:0] {HDR, COEF, CHILD, CSUM, WRITE} state_t;
  state_t                 state;
  logic [3:0]             cnt;
  logic [7:0]             csum;
  logic [ADDR_WIDTH-1:0]  addr_buf;
  logic [COEF_WIDTH-1:0]  coef_buf;
  logic [CHILD_WIDTH-1:0] child_buf;
  logic                   xfer;
  assign s_ready = state != WRITE;
  assign busy    = state != HDR;
  assign xfer    = s_valid && s_ready;
  // Frame FSM: assembles bytes into shadow buffers, publishes them to the SRAM ports only on a good checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HDR;
      cnt         <= '0;
      csum        <= '0;
      addr_buf    <= '0;
      coef_buf    <= '0;
      child_buf   <= '0;
      coef_addr   <= '0;
      coef_write  <= 1'b0;
      coef_data   <= '0;
      child_addr  <= '0;
      child_write <= 1'b0;
      child_data  <= '0;
      tree_ready  <= 1'b0;
      node_count  <= '0;
      err_count   <= '0;
    end else begin
      coef_write  <= 1'b0;
      child_write <= 1'b0;
      case (state)
        HDR: if (xfer) begin
          csum <= s_data;
          cnt  <= '0;
          if (s_data[7:6] == 2'b00) begin
            state      <= COEF;
            addr_buf   <= ADDR_WIDTH'(s_data[5:0]);
            tree_ready <= 1'b0;
          end else if (s_data[7:6] == 2'b01) tree_ready <= 1'b1;
          else err_count <= (err_count == 8'hff) ? err_count : err_count + 8'd1;
        end
        COEF: if (xfer) begin
          coef_buf <= {coef_buf[COEF_WIDTH-9:0], s_data};
          csum     <= csum ^ s_data;
          cnt      <= (cnt == 4'd5) ? 4'd0 : cnt + 4'd1;
          state    <= (cnt == 4'd5) ? CHILD : COEF;
        end
        CHILD: if (xfer) begin
          child_buf <= {child_buf[CHILD_WIDTH-9:0], s_data};
          csum      <= csum ^ s_data;
          cnt       <= (cnt == 4'd2) ? 4'd0 : cnt + 4'd1;
          state     <= (cnt == 4'd2) ? CSUM : CHILD;
        end
        CSUM: if (xfer) begin
          if (s_data == csum) begin
            state       <= WRITE;
            coef_write  <= 1'b1;
            child_write <= 1'b1;
            coef_addr   <= addr_buf;
            child_addr  <= addr_buf;
            coef_data   <= coef_buf;
            child_data  <= child_buf;
          end else begin
            state     <= HDR;
            err_count <= (err_count == 8'hff) ? err_count : err_count + 8'd1;
          end
        end
        WRITE: begin
          state      <= HDR;
          node_count <= (node_count == 7'h7f) ? node_count : node_count + 7'd1;
        end
        default: state <= HDR;
      endcase
    end
  end
endmodule
